// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM encoding for the binary-to-BCD converter

package bcd_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int          NUM_DIGITS = 8;
   localparam int          BCD_BITS   = 4 * NUM_DIGITS;
   localparam logic [31:0] MAX_VALUE  = 32'd99999999;
   localparam logic [31:0] ALL_NINES  = 32'h9999_9999;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - per-nibble add-3 correction used before each double-dabble shift

module bcd_digit_adjust (
   input  logic [3:0] nibble,
   output logic [3:0] adjusted
);

   // A nibble at most 9 becomes at most 12 here, so 4 bits never wrap.
   assign adjusted = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// rtl/bin_to_bcd_converter.sv - sequential double-dabble converter, one bit per clock, 8 BCD digits

module bin_to_bcd_converter
   import bcd_pkg::*;
#(
   parameter int WIDTH = 27
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Binary,
   output logic             Busy,
   output logic             Done,
   output logic             Overflow,
   output logic [3:0]       BCD7,
   output logic [3:0]       BCD6,
   output logic [3:0]       BCD5,
   output logic [3:0]       BCD4,
   output logic [3:0]       BCD3,
   output logic [3:0]       BCD2,
   output logic [3:0]       BCD1,
   output logic [3:0]       BCD0
);

   localparam int                CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

   state_t              state;
   logic [WIDTH-1:0]    shift_reg;
   logic [BCD_BITS-1:0] scratch;
   logic [CNT_W-1:0]    count;
   logic                ovf_pending;
   logic [BCD_BITS-1:0] bcd_q;

   logic [BCD_BITS-1:0] adjusted;
   logic [BCD_BITS:0]   shifted;
   logic [31:0]         binary_ext;
   logic                ovf_final;

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adjust
      bcd_digit_adjust u_adjust (
         .nibble   (scratch[4*d +: 4]),
         .adjusted (adjusted[4*d +: 4])
      );
   end

   // Bit BCD_BITS of the shift catches a ninth digit; treat it as overflow too.
   assign shifted    = {adjusted, shift_reg[WIDTH-1]};
   assign binary_ext = 32'(Binary);
   assign ovf_final  = ovf_pending | shifted[BCD_BITS];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         scratch     <= '0;
         count       <= '0;
         ovf_pending <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Overflow    <= 1'b0;
         bcd_q       <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  shift_reg   <= Binary;
                  scratch     <= '0;
                  count       <= '0;
                  ovf_pending <= (binary_ext > MAX_VALUE);
                  Busy        <= 1'b1;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               scratch   <= shifted[BCD_BITS-1:0];
               shift_reg <= shift_reg << 1;
               count     <= count + CNT_W'(1);
               if (count == LAST) begin
                  state    <= IDLE;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
                  Overflow <= ovf_final;
                  bcd_q    <= ovf_final ? ALL_NINES : shifted[BCD_BITS-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign {BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0} = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb/tb_bin_to_bcd_converter.sv - directed self-checking bench for bin_to_bcd_converter

module tb_bin_to_bcd_converter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [26:0] binary;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [3:0]  bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0;
   logic [31:0] digits;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   assign digits = {bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

   bin_to_bcd_converter #(.WIDTH(27)) dut (
      .Clk      (clk),
      .Reset    (reset),
      .Start    (start),
      .Binary   (binary),
      .Busy     (busy),
      .Done     (done),
      .Overflow (overflow),
      .BCD7     (bcd7),
      .BCD6     (bcd6),
      .BCD5     (bcd5),
      .BCD4     (bcd4),
      .BCD3     (bcd3),
      .BCD2     (bcd2),
      .BCD1     (bcd1),
      .BCD0     (bcd0)
   );

   task automatic start_conv(input logic [26:0] val);
      @(negedge clk);
      binary = val;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Counts negedges from the one just after the accepting edge up to the Done cycle.
   task automatic wait_done(output int cycles, output int busy_n);
      cycles = 1;
      busy_n = busy ? 1 : 0;
      while (!done && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (busy) busy_n++;
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      start  = 1'b0;
      binary = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else pass_cnt++;
      total_cnt++;
      if (digits !== 32'h0) $display("FAIL reset_digits: got %h expected 00000000", digits); else pass_cnt++;
   endtask

   task automatic test_zero();
      int cycles, busy_n;
      start_conv(27'd0);
      wait_done(cycles, busy_n);
      total_cnt++;
      if (cycles !== 28) $display("FAIL zero_latency: got %0d expected 28", cycles); else pass_cnt++;
      total_cnt++;
      if (busy_n !== 27) $display("FAIL zero_busy_cycles: got %0d expected 27", busy_n); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL zero_busy_at_done: got %b expected 0", busy); else pass_cnt++;
      total_cnt++;
      if (digits !== 32'h0) $display("FAIL zero_digits: got %h expected 00000000", digits); else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL zero_overflow: got %b expected 0", overflow); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0) $display("FAIL zero_done_width: got %b expected 0", done); else pass_cnt++;
   endtask

   task automatic test_12345678();
      int cycles, busy_n;
      start_conv(27'd12345678);
      wait_done(cycles, busy_n);
      total_cnt++;
      if (digits !== 32'h12345678) $display("FAIL conv_12345678: got %h expected 12345678", digits); else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL conv_12345678_ovf: got %b expected 0", overflow); else pass_cnt++;
   endtask

   task automatic test_overflow();
      int cycles, busy_n;
      start_conv(27'd99999999);
      wait_done(cycles, busy_n);
      total_cnt++;
      if (digits !== 32'h99999999) $display("FAIL max_digits: got %h expected 99999999", digits); else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL max_overflow: got %b expected 0", overflow); else pass_cnt++;
      start_conv(27'd100000000);
      wait_done(cycles, busy_n);
      total_cnt++;
      if (digits !== 32'h99999999) $display("FAIL sat_digits: got %h expected 99999999", digits); else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b1) $display("FAIL sat_overflow: got %b expected 1", overflow); else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (overflow !== 1'b1) $display("FAIL sat_overflow_held: got %b expected 1", overflow); else pass_cnt++;
   endtask

   task automatic test_start_while_busy();
      int k, extra_done;
      start_conv(27'd42);
      k = 1;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
         if (k == 10) begin
            binary = 27'd5;
            start  = 1'b1;
         end else begin
            start  = 1'b0;
         end
      end
      start = 1'b0;
      total_cnt++;
      if (k !== 28) $display("FAIL busy_start_latency: got %0d expected 28", k); else pass_cnt++;
      total_cnt++;
      if (digits !== 32'h00000042) $display("FAIL busy_start_digits: got %h expected 00000042", digits); else pass_cnt++;
      total_cnt++;
      if (overflow !== 1'b0) $display("FAIL busy_start_ovf_cleared: got %b expected 0", overflow); else pass_cnt++;
      extra_done = 0;
      repeat (35) begin
         @(negedge clk);
         if (done || busy) extra_done++;
      end
      total_cnt++;
      if (extra_done !== 0) $display("FAIL busy_start_single_done: got %0d extra active cycles expected 0", extra_done); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int cycles, busy_n, stray;
      start_conv(27'd87654321);
      for (int k = 1; k < 15; k++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++;
      if (digits !== 32'h0) $display("FAIL midreset_digits: got %h expected 00000000", digits); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else pass_cnt++;
      stray = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) stray++;
      end
      total_cnt++;
      if (stray !== 0) $display("FAIL midreset_no_done: got %0d expected 0", stray); else pass_cnt++;
      start_conv(27'd7);
      wait_done(cycles, busy_n);
      total_cnt++;
      if (cycles !== 28) $display("FAIL midreset_restart_latency: got %0d expected 28", cycles); else pass_cnt++;
      total_cnt++;
      if (digits !== 32'h00000007) $display("FAIL midreset_restart_digits: got %h expected 00000007", digits); else pass_cnt++;
   endtask

   task automatic test_held_start();
      logic [31:0] prev, exp;
      int k;
      bit stable;
      @(negedge clk);
      binary = 27'd1;
      start  = 1'b1;
      prev   = digits;
      for (int r = 0; r < 4; r++) begin
         k = 0;
         stable = 1'b1;
         do begin
            @(negedge clk);
            k++;
            if (!done && digits !== prev) stable = 1'b0;
         end while (!done && k < 100);
         exp = (r % 2 == 0) ? 32'h00000001 : 32'h00000009;
         total_cnt++;
         if (k !== 28) $display("FAIL held_period_%0d: got %0d expected 28", r, k); else pass_cnt++;
         total_cnt++;
         if (digits !== exp) $display("FAIL held_digits_%0d: got %h expected %h", r, digits, exp); else pass_cnt++;
         total_cnt++;
         if (stable !== 1'b1) $display("FAIL held_stable_%0d: got %b expected 1", r, stable); else pass_cnt++;
         prev   = exp;
         binary = (r % 2 == 0) ? 27'd9 : 27'd1;
      end
      start = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      binary = '0;
      test_reset();
      test_zero();
      test_12345678();
      test_overflow();
      test_start_while_busy();
      test_reset_mid();
      test_held_start();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
